tug_round_ctrl: RTL and testbench

Round and match sequencer for the tug-of-war playfield. Synchronizes and edge-detects the two player keys, forwards single-cycle press pulses to the light cells, and detects a round win when a press drives the light off either end. It then updates per-player scores, recenters the field through `resetround`, and ends the match at a configured winning score. It sits between the raw key inputs and the row of light cells, and drives their `L`, `R` and `resetround` inputs.

---
 rtl/tug_round_ctrl.sv | 132 +++++++++++++
 tb/tb_tug_round_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tug_round_ctrl.sv
// Tug-of-war round/match sequencer: key sync + edge detect, win detection, scoring, recenter.
// Optional post-win pause state enabled by defining TUG_ROUND_PAUSE_EN.
module tug_round_ctrl #(
    parameter int NUM_LIGHTS = 9,
    parameter int SCORE_W    = 3,
    parameter int WIN_SCORE  = 7,
    parameter int PAUSE_CYC  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  keyL,
    input  logic                  keyR,
    input  logic [NUM_LIGHTS-1:0] lights,
    output logic                  L,
    output logic                  R,
    output logic                  resetround,
    output logic [SCORE_W-1:0]    scoreL,
    output logic [SCORE_W-1:0]    scoreR,
    output logic [1:0]            winner,
    output logic                  matchOver
);

`ifdef TUG_ROUND_PAUSE_EN
    typedef enum logic [1:0] {PLAY, PAUSE, RECENTER, MATCH_OVER} state_t;
    localparam int CNT_W = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {PLAY, RECENTER, MATCH_OVER} state_t;
`endif

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    // Bit 0 is the first synchronizer stage, bit 2 the edge-detect history.
    logic [2:0]         sync_l_q, sync_l_d;
    logic [2:0]         sync_r_q, sync_r_d;

    logic press_l, press_r, win_l, win_r;
    logic [SCORE_W-1:0] score_l_inc, score_r_inc;

    // Only the two end cells can signal a win; the middle cells are observed by nobody here.
    logic unused_inputs;
    assign unused_inputs = ^{lights[NUM_LIGHTS-2:1], (PAUSE_CYC > 0)};

    assign press_l     = sync_l_q[1] & ~sync_l_q[2];
    assign press_r     = sync_r_q[1] & ~sync_r_q[2];
    assign win_l       = press_l & ~press_r & lights[NUM_LIGHTS-1];
    assign win_r       = press_r & ~press_l & lights[0];
    assign score_l_inc = score_l_q + SCORE_W'(1);
    assign score_r_inc = score_r_q + SCORE_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        sync_l_d   = {sync_l_q[1:0], keyL};
        sync_r_d   = {sync_r_q[1:0], keyR};
        L          = 1'b0;
        R          = 1'b0;
        resetround = 1'b0;
`ifdef TUG_ROUND_PAUSE_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            PLAY: begin
                L = press_l;
                R = press_r;
                if (win_l || win_r) begin
                    if (win_l) score_l_d = score_l_inc;
                    else       score_r_d = score_r_inc;
                    if ((win_l && score_l_inc == WIN_VAL) || (win_r && score_r_inc == WIN_VAL)) begin
                        state_d = MATCH_OVER;
                    end else begin
`ifdef TUG_ROUND_PAUSE_EN
                        state_d = PAUSE;
                        cnt_d   = CNT_W'(PAUSE_CYC - 1);
`else
                        state_d = RECENTER;
`endif
                    end
                end
            end
`ifdef TUG_ROUND_PAUSE_EN
            PAUSE: begin
                if (cnt_q == '0) state_d = RECENTER;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
`endif
            RECENTER: begin
                resetround = 1'b1;
                state_d    = PLAY;
            end
            MATCH_OVER: begin
                resetround = 1'b1;
            end
            default: state_d = PLAY;
        endcase
    end

    assign matchOver = (state_q == MATCH_OVER);
    assign winner    = matchOver ? {score_l_q == WIN_VAL, score_r_q == WIN_VAL} : 2'b00;
    assign scoreL    = score_l_q;
    assign scoreR    = score_r_q;

    // NOTE: non-blocking assignments so every flop samples pre-edge values in parallel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PLAY;
            score_l_q <= '0;
            score_r_q <= '0;
            sync_l_q  <= '0;
            sync_r_q  <= '0;
`ifdef TUG_ROUND_PAUSE_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            sync_l_q  <= sync_l_d;
            sync_r_q  <= sync_r_d;
`ifdef TUG_ROUND_PAUSE_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_tug_round_ctrl.sv
// Self-checking bench for tug_round_ctrl: directed scenarios plus random keys/lights vs a
// cycle-level reference model built from key sample history and round/match rules.
module tb_tug_round_ctrl;

    localparam int NUM_LIGHTS = 9;
    localparam int WIN_SCORE  = 7;
    localparam int PAUSE_CYC  = 4;
`ifdef TUG_ROUND_PAUSE_EN
    localparam int RR_OFF = PAUSE_CYC + 1;
`else
    localparam int RR_OFF = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       keyL = 1'b0, keyR = 1'b0;
    logic [8:0] lights = '0;
    logic       L, R, resetround, matchOver;
    logic [2:0] scoreL, scoreR;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;

    tug_round_ctrl #(
        .NUM_LIGHTS(NUM_LIGHTS), .SCORE_W(3), .WIN_SCORE(WIN_SCORE), .PAUSE_CYC(PAUSE_CYC)
    ) dut (
        .clk(clk), .reset(reset), .keyL(keyL), .keyR(keyR), .lights(lights),
        .L(L), .R(R), .resetround(resetround), .scoreL(scoreL), .scoreR(scoreR),
        .winner(winner), .matchOver(matchOver)
    );

    always #5 clk = ~clk;

    wire [11:0] dut_vec = {L, R, resetround, scoreL, scoreR, winner, matchOver};

    // Reference model: key samples per edge, scores, and remaining non-play time.
    bit q_l[$] = '{1'b0, 1'b0, 1'b0};
    bit q_r[$] = '{1'b0, 1'b0, 1'b0};
    int m_sl = 0, m_sr = 0, m_pause = 0;
    bit m_recenter = 0, m_over = 0;

    function automatic bit m_play();
        return !m_over && m_pause == 0 && !m_recenter;
    endfunction

    function automatic bit pulse_of(input bit h2, input bit h3);
        return h2 && !h3;
    endfunction

    function automatic logic [11:0] model_vec();
        bit pl, pr;
        logic [1:0] w;
        pl = pulse_of(q_l[q_l.size()-2], q_l[q_l.size()-3]);
        pr = pulse_of(q_r[q_r.size()-2], q_r[q_r.size()-3]);
        w  = !m_over ? 2'b00 : (m_sl == WIN_SCORE ? 2'b10 : 2'b01);
        return {m_play() && pl, m_play() && pr, m_recenter || m_over, 3'(m_sl), 3'(m_sr), w, m_over};
    endfunction

    function automatic void after_win(input int s);
        if (s == WIN_SCORE) m_over = 1;
`ifdef TUG_ROUND_PAUSE_EN
        else m_pause = PAUSE_CYC;
`else
        else m_recenter = 1;
`endif
    endfunction

    always @(posedge clk) begin
        bit pl, pr;
        if (reset) begin
            m_sl = 0; m_sr = 0; m_pause = 0; m_recenter = 0; m_over = 0;
            q_l = '{1'b0, 1'b0, 1'b0};
            q_r = '{1'b0, 1'b0, 1'b0};
        end else begin
            pl = pulse_of(q_l[q_l.size()-2], q_l[q_l.size()-3]);
            pr = pulse_of(q_r[q_r.size()-2], q_r[q_r.size()-3]);
            if (m_play()) begin
                if (pl && !pr && lights[8]) begin m_sl++; after_win(m_sl); end
                else if (pr && !pl && lights[0]) begin m_sr++; after_win(m_sr); end
            end else if (m_pause > 0) begin
                m_pause--;
                if (m_pause == 0) m_recenter = 1;
            end else if (m_recenter) begin
                m_recenter = 0;
            end
            q_l.push_back(keyL);
            q_r.push_back(keyR);
            if (q_l.size() > 6) begin void'(q_l.pop_front()); void'(q_r.pop_front()); end
        end
    end

    task automatic do_reset();
        reset = 1'b1; keyL = 1'b0; keyR = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        keyL = 1'b1; keyR = 1'b1; lights = '1; reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (dut_vec !== 12'b0) begin
            bad++; $display("FAIL reset_values got=%b want=%b", dut_vec, 12'b0);
        end
        do_reset();
    endtask

    task automatic test_single_press();
        int seen = 0, at = -1, rseen = 0;
        do_reset(); lights = '0;
        keyL = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL single_press c=%0d got=%b want=%b", c, dut_vec, model_vec());
            end
            if (L) begin seen++; at = c; end
            if (R) rseen++;
            if (c == 5) keyL = 1'b0;
        end
        total++;
        if (seen !== 1 || at !== 2 || rseen !== 0) begin
            bad++; $display("FAIL single_press_pulse got=%0d@%0d r=%0d want=1@2 r=0", seen, at, rseen);
        end
    endtask

    task automatic test_left_win();
        int cl = -1, crr = -1, seen = 0;
        do_reset(); lights = 9'h100;
        keyL = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL left_win c=%0d got=%b want=%b", c, dut_vec, model_vec());
            end
            if (L && cl < 0) cl = c;
            if (resetround && crr < 0) crr = c;
            if (c == 3) keyL = 1'b0;
        end
        total++;
        if (scoreL !== 3'd1 || crr - cl !== RR_OFF) begin
            bad++; $display("FAIL left_win_timing got=score%0d off%0d want=score1 off%0d", scoreL, crr - cl, RR_OFF);
        end
        lights = '0; keyL = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (L) seen++;
        end
        keyL = 1'b0;
        total++;
        if (seen !== 1) begin
            bad++; $display("FAIL left_win_replay got=%0d want=1", seen);
        end
    endtask

    task automatic test_simultaneous();
        int both = 0, rr = 0;
        do_reset(); lights = 9'h001;
        keyL = 1'b1; keyR = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL simultaneous c=%0d got=%b want=%b", c, dut_vec, model_vec());
            end
            if (L && R) both++;
            if (resetround) rr++;
        end
        keyL = 1'b0; keyR = 1'b0;
        total++;
        if (both !== 1 || rr !== 0 || scoreL !== 3'd0 || scoreR !== 3'd0) begin
            bad++; $display("FAIL simultaneous_result got=both%0d rr%0d %0d:%0d want=both1 rr0 0:0", both, rr, scoreL, scoreR);
        end
    endtask

    task automatic test_right_match();
        int pulses = 0;
        do_reset(); lights = 9'h001;
        for (int r = 0; r < WIN_SCORE; r++) begin
            keyR = 1'b1;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                total++;
                if (dut_vec !== model_vec()) begin
                    bad++; $display("FAIL right_match r=%0d c=%0d got=%b want=%b", r, c, dut_vec, model_vec());
                end
                if (c == 2) keyR = 1'b0;
            end
        end
        total++;
        if (scoreR !== 3'd7 || winner !== 2'b01 || matchOver !== 1'b1 || resetround !== 1'b1) begin
            bad++; $display("FAIL right_match_end got=s%0d w%b m%b rr%b want=s7 w01 m1 rr1", scoreR, winner, matchOver, resetround);
        end
        lights = 9'h101;
        for (int c = 0; c < 12; c++) begin
            keyL = c[1]; keyR = c[2];
            @(negedge clk);
            if (L || R) pulses++;
        end
        keyL = 1'b0; keyR = 1'b0;
        total++;
        if (pulses !== 0 || scoreR !== 3'd7 || scoreL !== 3'd0) begin
            bad++; $display("FAIL right_match_frozen got=p%0d %0d:%0d want=p0 0:7", pulses, scoreL, scoreR);
        end
    endtask

    task automatic test_reset_in_pause();
        int seen = 0;
        do_reset(); lights = 9'h100;
        for (int r = 0; r < 3; r++) begin
            keyL = 1'b1;
            for (int c = 1; c <= ((r == 2) ? 3 : 10); c++) begin
                @(negedge clk);
                total++;
                if (dut_vec !== model_vec()) begin
                    bad++; $display("FAIL reset_in_pause r=%0d c=%0d got=%b want=%b", r, c, dut_vec, model_vec());
                end
                if (c == 2) keyL = 1'b0;
            end
        end
        total++;
        if (scoreL !== 3'd3) begin
            bad++; $display("FAIL reset_in_pause_score got=%0d want=3", scoreL);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (dut_vec !== 12'b0) begin
            bad++; $display("FAIL reset_in_pause_clear got=%b want=%b", dut_vec, 12'b0);
        end
        lights = '0; keyL = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (L) seen++;
        end
        keyL = 1'b0;
        total++;
        if (seen !== 1) begin
            bad++; $display("FAIL reset_in_pause_press got=%0d want=1", seen);
        end
    endtask

    task automatic test_held_key();
        int seen = 0;
        do_reset(); lights = 9'h100;
        keyL = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL held_key c=%0d got=%b want=%b", c, dut_vec, model_vec());
            end
            if (L) seen++;
            if (c == 16) keyL = 1'b0;
            if (c == 18) keyL = 1'b1;
        end
        keyL = 1'b0;
        total++;
        if (seen !== 2) begin
            bad++; $display("FAIL held_key_pulses got=%0d want=2", seen);
        end
    endtask

    task automatic test_random();
        logic [8:0] lv;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            total++;
            if (dut_vec !== model_vec()) begin
                bad++; $display("FAIL random c=%0d got=%b want=%b", c, dut_vec, model_vec());
            end
            if ($urandom_range(3) == 0) keyL = ~keyL;
            if ($urandom_range(3) == 0) keyR = ~keyR;
            lv = 9'($urandom);
            lv[8] = $urandom_range(1) == 1;
            lv[0] = $urandom_range(1) == 1;
            lights = lv;
            reset = ($urandom_range(299) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_left_win();
        test_simultaneous();
        test_right_match();
        test_reset_in_pause();
        test_held_key();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
